// File: rtl/keccak_ctrl_pkg.sv
// Shared types and defaults for the Keccak step controller.
// Holds the state encoding, the registered output bundle and its decoder.
package keccak_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_CAL   = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } ctrl_state_e;

  localparam int DEF_N_LINES    = 64;
  localparam int DEF_N_ROUNDS   = 1;
  localparam int DEF_CAL_CYCLES = 1;

  typedef struct packed {
    logic clr;
    logic read_file;
    logic write_reg;
    logic fb_sel;
    logic cal_en;
    logic write_file;
    logic busy;
    logic done;
  } ctrl_out_t;

  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Moore decode of a state; fb is only honoured in LOAD.
  function automatic ctrl_out_t decode_outputs(input ctrl_state_e st, input logic fb);
    ctrl_out_t o;
    o      = '0;
    o.busy = (st != ST_IDLE);
    case (st)
      ST_INIT: begin
        o.clr       = 1'b1;
        o.read_file = 1'b1;
      end
      ST_LOAD: begin
        o.write_reg = 1'b1;
        o.fb_sel    = fb;
      end
      ST_CAL:   o.cal_en     = 1'b1;
      ST_WRITE: o.write_file = 1'b1;
      ST_DONE:  o.done       = 1'b1;
      default:  o.busy       = (st != ST_IDLE);
    endcase
    return o;
  endfunction

endpackage

// File: rtl/keccak_step_ctrl_step_counter.sv
// Saturating up-counter with clear; stops at LAST so it never wraps.
module step_counter #(
  parameter int W    = 1,
  parameter int LAST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         at_last
);

  logic [W-1:0] cnt_r;

  assign value   = cnt_r;
  assign at_last = (cnt_r == W'(LAST));

  // count register: clear wins over increment, hold once terminal
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !at_last) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/keccak_step_ctrl.sv
// Sequencer for a line-by-line Keccak datapath: load, iterate rounds, write back.
// Strobes are registered from the next state so they line up with state_r.
module keccak_step_ctrl
  import keccak_ctrl_pkg::*;
#(
  parameter  int N_LINES    = DEF_N_LINES,
  parameter  int N_ROUNDS   = DEF_N_ROUNDS,
  parameter  int CAL_CYCLES = DEF_CAL_CYCLES,
  localparam int LW         = cnt_width(N_LINES),
  localparam int RW         = cnt_width(N_ROUNDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [LW-1:0] line_index,
  output logic [RW-1:0] round_index,
  output logic          clr,
  output logic          read_file,
  output logic          write_reg,
  output logic          fb_sel,
  output logic          cal_en,
  output logic          write_file,
  output logic          busy,
  output logic          done
);

  localparam int CW = cnt_width(CAL_CYCLES);

  ctrl_state_e   state_r;
  ctrl_state_e   state_nx_s;
  ctrl_out_t     out_r;
  logic          fb_nx_s;
  logic          line_clr_s, line_inc_s, line_last_s;
  logic          round_clr_s, round_inc_s, round_last_s;
  logic          lat_clr_s, lat_inc_s, lat_last_s;
  logic [CW-1:0] lat_cnt_s;

  step_counter #(.W(LW), .LAST(N_LINES - 1)) u_line_cnt (
    .clk(clk), .rst(rst), .clr(line_clr_s), .inc(line_inc_s),
    .value(line_index), .at_last(line_last_s)
  );

  step_counter #(.W(RW), .LAST(N_ROUNDS - 1)) u_round_cnt (
    .clk(clk), .rst(rst), .clr(round_clr_s), .inc(round_inc_s),
    .value(round_index), .at_last(round_last_s)
  );

  step_counter #(.W(CW), .LAST(CAL_CYCLES - 1)) u_lat_cnt (
    .clk(clk), .rst(rst), .clr(lat_clr_s), .inc(lat_inc_s),
    .value(lat_cnt_s), .at_last(lat_last_s)
  );

  // counter control; an aborting cycle leaves the counters untouched
  always_comb begin
    line_clr_s  = 1'b0;
    line_inc_s  = 1'b0;
    round_clr_s = 1'b0;
    round_inc_s = 1'b0;
    lat_clr_s   = 1'b0;
    lat_inc_s   = 1'b0;
    if (!abort) begin
      case (state_r)
        ST_INIT: begin
          line_clr_s  = 1'b1;
          round_clr_s = 1'b1;
          lat_clr_s   = 1'b1;
        end
        ST_LOAD: lat_clr_s = 1'b1;
        ST_CAL: begin
          lat_inc_s   = !lat_last_s;
          round_inc_s = lat_last_s && !round_last_s;
        end
        ST_WRITE: begin
          line_inc_s  = !line_last_s;
          round_clr_s = !line_last_s;
        end
        default: lat_clr_s = 1'b0;
      endcase
    end else begin
      lat_clr_s = 1'b0;
    end
  end

  // next-state logic; abort outside IDLE overrides every transition
  always_comb begin
    state_nx_s = state_r;
    fb_nx_s    = (state_r == ST_CAL);
    case (state_r)
      ST_IDLE:  state_nx_s = (start && !abort) ? ST_INIT : ST_IDLE;
      ST_INIT:  state_nx_s = ST_READ;
      ST_READ:  state_nx_s = ST_LOAD;
      ST_LOAD:  state_nx_s = ST_CAL;
      ST_CAL: begin
        if (lat_last_s) begin
          state_nx_s = round_last_s ? ST_WRITE : ST_LOAD;
        end else begin
          state_nx_s = ST_CAL;
        end
      end
      ST_WRITE: state_nx_s = line_last_s ? ST_DONE : ST_LOAD;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
    if (abort && (state_r != ST_IDLE)) begin
      state_nx_s = ST_IDLE;
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // state and registered output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      out_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      out_r   <= decode_outputs(state_nx_s, fb_nx_s);
    end
  end

  assign clr        = out_r.clr;
  assign read_file  = out_r.read_file;
  assign write_reg  = out_r.write_reg;
  assign fb_sel     = out_r.fb_sel;
  assign cal_en     = out_r.cal_en;
  assign write_file = out_r.write_file;
  assign busy       = out_r.busy;
  assign done       = out_r.done;

endmodule

// File: doc/keccak_step_ctrl.md
KECCAK_STEP_CTRL -- requirements
Module: keccak_step_ctrl

Interface
REQ-001 Parameter N_LINES, default 64, number of state lines processed per job (>=1).
REQ-002 Parameter N_ROUNDS, default 1, rounds applied to each line before write-back (>=1).
REQ-003 Parameter CAL_CYCLES, default 1, datapath compute latency per round in cycles (>=1).
REQ-004 Parameters LW = max(1,$clog2(N_LINES)) and RW = max(1,$clog2(N_ROUNDS)) are derived, not user-set.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  job request, sampled only in IDLE.
REQ-008 abort  in  1  cancel current job.
REQ-009 line_index  out  LW  current line number.
REQ-010 round_index  out  RW  current round number, used as round-constant select.
REQ-011 clr  out  1  datapath clear pulse.
REQ-012 read_file  out  1  input-file load strobe.
REQ-013 write_reg  out  1  state-register load strobe.
REQ-014 fb_sel  out  1  register source: 0 = file line, 1 = datapath feedback.
REQ-015 cal_en  out  1  datapath compute enable.
REQ-016 write_file  out  1  output-file write strobe for line_index.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle job-complete pulse.

Function
REQ-019 States SHALL be IDLE, INIT, READ, LOAD, CAL, WRITE and DONE, registered as a Moore FSM; all outputs decode from the state and counters only.
REQ-020 IDLE -> INIT when start=1, otherwise stay in IDLE; start in any other state SHALL be ignored.
REQ-021 INIT (1 cycle): clr=1, read_file=1; line_cnt, round_cnt and lat_cnt are cleared; next state is READ.
REQ-022 READ (1 cycle): no strobes; next state is LOAD.
REQ-023 LOAD (1 cycle): write_reg=1 and fb_sel=(round_cnt!=0); lat_cnt is cleared; next state is CAL.
REQ-024 CAL: cal_en=1 for exactly CAL_CYCLES cycles, counted by lat_cnt.
REQ-025 On the last CAL cycle: if round_cnt==N_ROUNDS-1, go to WRITE; otherwise round_cnt increments and the FSM returns to LOAD.
REQ-026 WRITE (1 cycle): write_file=1.
REQ-027 Leaving WRITE: if line_cnt==N_LINES-1, go to DONE; otherwise line_cnt increments, round_cnt clears to 0, and the FSM goes to LOAD.
REQ-028 DONE (1 cycle): done=1; next state is IDLE. Counters hold their final values until the next INIT.
REQ-029 line_index=line_cnt and round_index=round_cnt, both combinational from the registers.
REQ-030 Counters SHALL never wrap: terminal compares use N_LINES-1 and N_ROUNDS-1, so non-power-of-2 values are legal.
REQ-031 Job length from INIT through DONE, inclusive, SHALL be 3 + N_LINES*(N_ROUNDS*(1+CAL_CYCLES)+1) cycles.
REQ-032 abort=1 in any non-IDLE state forces IDLE at the next edge, with no done pulse; abort has priority over every other transition.
REQ-033 abort in IDLE SHALL have no effect; if start and abort are both high in IDLE, the FSM stays in IDLE.
REQ-034 At most one of read_file, write_reg, cal_en and write_file SHALL be high in any cycle.

Reset
REQ-035 rst takes priority over abort and start; the FSM enters IDLE at the next edge.
REQ-036 After reset, all counters are 0 and every output is 0, including busy and done.
REQ-037 rst asserted mid-job SHALL discard the job; no done or write_file pulse follows it.

Structure
REQ-038 Package keccak_ctrl_pkg SHALL hold the state enumeration (3-bit encoding, IDLE=0) and the default parameter constants.
REQ-039 Sub-module step_counter (parametrised width and terminal value, with clr, inc and at_last outputs) SHALL be instantiated three times: line, round and latency.

Verification
REQ-040 Defaults (64,1,1): pulse start -> exactly 64 write_file pulses with line_index 0..63; done in cycle 195 after INIT; busy low afterwards.
REQ-041 N_LINES=4, N_ROUNDS=3, CAL_CYCLES=2: pulse start -> done in cycle 43 after INIT; per line, round_index sequences 0,1,2 and fb_sel=0,1,1 on write_reg.
REQ-042 N_LINES=5 (non-power-of-2): after 5 write_file pulses (line_index 4 last), done fires and line_index never reaches 5.
REQ-043 abort asserted during line 10 CAL -> IDLE next cycle, busy=0, no done; a new start then replays from line_index 0.
REQ-044 rst asserted during WRITE of line 7 -> next cycle all outputs are 0 and the state is IDLE; start held high during busy causes no restart or extra INIT.
REQ-045 Assertion runs in every test: REQ-034 one-hot strobe check, and done is never high for two consecutive cycles.
